// File: rtl/hyperbus_mem_responder.sv
// hyperbus_mem_responder
// HyperBus memory-side target. The system clock oversamples the HyperBus clock
// (at least 4x), decodes the 48-bit command/address phase, counts the initial
// latency and then serves read bursts from, or writes bursts into, a simple
// SRAM-style port (read data valid the cycle after the strobe).
// Optional build macro: HYPERBUS_RESP_DOUBLE_LATENCY_EN
//   defined   -> RWDS high during CA, latency = 2*WAIT_CYCLES
//   undefined -> RWDS low during CA,  latency = WAIT_CYCLES
module hyperbus_mem_responder #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          WAIT_CYCLES = 6,
  parameter logic [15:0] CFG_RESET   = 16'h8F1F
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hyper_cs_ni,
  input  logic                  hyper_ck_i,
  input  logic [7:0]            hyper_dq_i,
  output logic [7:0]            hyper_dq_o,
  output logic                  hyper_dq_oe_o,
  input  logic                  hyper_rwds_i,
  output logic                  hyper_rwds_o,
  output logic                  hyper_rwds_oe_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  output logic [1:0]            mem_be_o,
  input  logic [15:0]           mem_rdata_i,
  output logic [15:0]           cfg_o
);

`ifdef HYPERBUS_RESP_DOUBLE_LATENCY_EN
  localparam logic LAT_FLAG = 1'b1;
  localparam int   LAT      = 2 * WAIT_CYCLES;
`else
  localparam logic LAT_FLAG = 1'b0;
  localparam int   LAT      = WAIT_CYCLES;
`endif
  localparam logic [4:0] LAT_LOAD = 5'(LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LATENCY,
    S_RD,
    S_WR,
    S_REG_WR
  } state_t;

  // Synchronizer bus layout: {cs_n, ck, rwds, dq[7:0]}
  logic [10:0] sync1_reg, sync2_reg;
  logic        ck_prev_reg;

  logic       cs_s, ck_s, rwds_s;
  logic [7:0] dq_s;
  logic       ck_rise, ck_fall, ck_edge;

  state_t                  state_reg, state_next;
  logic [2:0]              byte_cnt_reg, byte_cnt_next;
  logic [39:0]             ca_reg, ca_next;
  logic [4:0]              lat_cnt_reg, lat_cnt_next;
  logic                    is_read_reg, is_read_next;
  logic                    is_reg_reg, is_reg_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [7:0]              hi_byte_reg, hi_byte_next;
  logic                    hi_mask_reg, hi_mask_next;
  logic                    hi_valid_reg, hi_valid_next;
  logic                    reg_done_reg, reg_done_next;
  logic [15:0]             rd_word_reg, rd_word_next;
  logic [15:0]             rd_next_reg, rd_next_next;
  logic                    rd_pend_reg, rd_pend_next;
  logic [7:0]              dq_reg, dq_next;
  logic                    rwds_reg, rwds_next;
  logic                    mem_req_reg, mem_req_next;
  logic                    mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic [15:0]             mem_wdata_reg, mem_wdata_next;
  logic [1:0]              mem_be_reg, mem_be_next;
  logic [15:0]             cfg_reg, cfg_next;

  logic [47:0]             ca_shift;
  logic [31:0]             ca_addr;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [15:0]             fetched_word, rise_word;
  logic                    data_rise;
  logic                    unused_bits;

  // Two-flop synchronizers for every HyperBus input, plus the previous ck for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg   <= 11'b100_0000_0000;
      sync2_reg   <= 11'b100_0000_0000;
      ck_prev_reg <= 1'b0;
    end else begin
      sync1_reg   <= {hyper_cs_ni, hyper_ck_i, hyper_rwds_i, hyper_dq_i};
      sync2_reg   <= sync1_reg;
      ck_prev_reg <= sync2_reg[9];
    end
  end

  assign cs_s    = sync2_reg[10];
  assign ck_s    = sync2_reg[9];
  assign rwds_s  = sync2_reg[8];
  assign dq_s    = sync2_reg[7:0];
  assign ck_rise = ck_s & ~ck_prev_reg;
  assign ck_fall = ~ck_s & ck_prev_reg;
  assign ck_edge = ck_rise | ck_fall;

  // CA bytes arrive MSB first; the decode uses the word including the byte on this edge
  assign ca_shift = {ca_reg, dq_s};
  assign ca_addr  = {ca_shift[44:16], ca_shift[2:0]};
  assign addr_inc = addr_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Read data arrives one cycle after the strobe; bypass it when it lands on the edge cycle
  assign fetched_word = rd_pend_reg ? mem_rdata_i : rd_next_reg;
  assign rise_word    = is_reg_reg ? cfg_reg : fetched_word;

  // Rising edge carrying data: in a burst, or the last latency edge which starts the burst
  assign data_rise = ck_rise &&
                     ((state_reg == S_RD) || (state_reg == S_WR) ||
                      ((state_reg == S_LATENCY) && (lat_cnt_reg == 5'd1)));

  // Wrapped-burst flag and reserved CA bits do not affect behaviour
  assign unused_bits = ^{ca_shift[45], ca_shift[15:3], ca_addr};

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      byte_cnt_reg  <= 3'd0;
      ca_reg        <= 40'd0;
      lat_cnt_reg   <= 5'd0;
      is_read_reg   <= 1'b0;
      is_reg_reg    <= 1'b0;
      addr_reg      <= '0;
      hi_byte_reg   <= 8'd0;
      hi_mask_reg   <= 1'b0;
      hi_valid_reg  <= 1'b0;
      reg_done_reg  <= 1'b0;
      rd_word_reg   <= 16'd0;
      rd_next_reg   <= 16'd0;
      rd_pend_reg   <= 1'b0;
      dq_reg        <= 8'd0;
      rwds_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 16'd0;
      mem_be_reg    <= 2'b00;
      cfg_reg       <= CFG_RESET;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      ca_reg        <= ca_next;
      lat_cnt_reg   <= lat_cnt_next;
      is_read_reg   <= is_read_next;
      is_reg_reg    <= is_reg_next;
      addr_reg      <= addr_next;
      hi_byte_reg   <= hi_byte_next;
      hi_mask_reg   <= hi_mask_next;
      hi_valid_reg  <= hi_valid_next;
      reg_done_reg  <= reg_done_next;
      rd_word_reg   <= rd_word_next;
      rd_next_reg   <= rd_next_next;
      rd_pend_reg   <= rd_pend_next;
      dq_reg        <= dq_next;
      rwds_reg      <= rwds_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      cfg_reg       <= cfg_next;
    end
  end

  // Next-state and datapath decisions; a CS rise overrides any ck edge in the same cycle
  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    ca_next        = ca_reg;
    lat_cnt_next   = lat_cnt_reg;
    is_read_next   = is_read_reg;
    is_reg_next    = is_reg_reg;
    addr_next      = addr_reg;
    hi_byte_next   = hi_byte_reg;
    hi_mask_next   = hi_mask_reg;
    hi_valid_next  = hi_valid_reg;
    reg_done_next  = reg_done_reg;
    rd_word_next   = rd_word_reg;
    rd_next_next   = rd_next_reg;
    rd_pend_next   = mem_req_reg & ~mem_we_reg;
    dq_next        = dq_reg;
    rwds_next      = rwds_reg;
    mem_req_next   = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    cfg_next       = cfg_reg;

    if (rd_pend_reg) begin
      rd_next_next = mem_rdata_i;
    end

    if ((state_reg != S_IDLE) && cs_s) begin
      // End of transaction: drop everything, a half-captured write word is lost
      state_next    = S_IDLE;
      hi_valid_next = 1'b0;
      dq_next       = 8'd0;
      rwds_next     = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (!cs_s) begin
            state_next    = S_CA;
            byte_cnt_next = 3'd0;
            hi_valid_next = 1'b0;
            reg_done_next = 1'b0;
          end
        end

        S_CA: begin
          if (ck_edge) begin
            ca_next       = ca_shift[39:0];
            byte_cnt_next = byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == 3'd5) begin
              is_read_next = ca_shift[47];
              is_reg_next  = ca_shift[46];
              addr_next    = ca_addr[ADDR_WIDTH-1:0];
              if (!ca_shift[47] && ca_shift[46]) begin
                state_next = S_REG_WR;
              end else begin
                state_next   = S_LATENCY;
                lat_cnt_next = LAT_LOAD;
                if (ca_shift[47] && !ca_shift[46]) begin
                  // Fetch the first word early so it is ready when latency expires
                  mem_req_next  = 1'b1;
                  mem_we_next   = 1'b0;
                  mem_addr_next = ca_addr[ADDR_WIDTH-1:0];
                end
              end
            end
          end
        end

        S_LATENCY: begin
          if (ck_rise && (lat_cnt_reg != 5'd1)) begin
            lat_cnt_next = lat_cnt_reg - 5'd1;
          end
        end

        S_RD: begin
          if (ck_fall) begin
            dq_next   = rd_word_reg[7:0];
            rwds_next = 1'b0;
          end
        end

        S_WR: begin
          if (ck_fall && hi_valid_reg) begin
            mem_req_next   = 1'b1;
            mem_we_next    = 1'b1;
            mem_addr_next  = addr_reg;
            mem_wdata_next = {hi_byte_reg, dq_s};
            mem_be_next    = ~{hi_mask_reg, rwds_s};
            addr_next      = addr_inc;
            hi_valid_next  = 1'b0;
          end
        end

        S_REG_WR: begin
          if (!reg_done_reg) begin
            if (ck_rise) begin
              hi_byte_next  = dq_s;
              hi_valid_next = 1'b1;
            end else if (ck_fall && hi_valid_reg) begin
              cfg_next      = {hi_byte_reg, dq_s};
              hi_valid_next = 1'b0;
              reg_done_next = 1'b1;
            end
          end
        end

        default: state_next = S_IDLE;
      endcase

      // Rising-edge half of each data word, shared by the last latency edge and the bursts
      if (data_rise) begin
        if (is_read_reg) begin
          state_next   = S_RD;
          dq_next      = rise_word[15:8];
          rwds_next    = 1'b1;
          rd_word_next = rise_word;
          if (!is_reg_reg) begin
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = addr_inc;
            addr_next     = addr_inc;
          end
        end else begin
          state_next    = S_WR;
          hi_byte_next  = dq_s;
          hi_mask_next  = rwds_s;
          hi_valid_next = 1'b1;
        end
      end
    end
  end

  assign hyper_dq_o      = dq_reg;
  assign hyper_dq_oe_o   = (state_reg == S_RD);
  assign hyper_rwds_oe_o = (state_reg == S_CA) || (state_reg == S_RD);
  assign hyper_rwds_o    = (state_reg == S_CA) ? LAT_FLAG : rwds_reg;
  assign mem_req_o       = mem_req_reg;
  assign mem_we_o        = mem_we_reg;
  assign mem_addr_o      = mem_addr_reg;
  assign mem_wdata_o     = mem_wdata_reg;
  assign mem_be_o        = mem_be_reg;
  assign cfg_o           = cfg_reg;

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Testbench for hyperbus_mem_responder: directed HyperBus transactions, with
// expected memory strobes and read bytes queued at stimulus time and checked by
// separate monitor processes.
module tb_hyperbus_mem_responder;

  localparam int WAIT_CYCLES = 6;
`ifdef HYPERBUS_RESP_DOUBLE_LATENCY_EN
  localparam int   LAT      = 2 * WAIT_CYCLES;
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam int   LAT      = WAIT_CYCLES;
  localparam logic EXP_FLAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hyper_cs_ni = 1'b1;
  logic        hyper_ck_i = 1'b0;
  logic [7:0]  hyper_dq_i = 8'h00;
  logic        hyper_rwds_i = 1'b0;
  logic [7:0]  hyper_dq_o;
  logic        hyper_dq_oe_o;
  logic        hyper_rwds_o;
  logic        hyper_rwds_oe_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] cfg_o;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } mem_t;

  mem_t        exp_mem[$];
  logic [9:0]  exp_dq[$];   // {dq_oe, rwds, byte}
  mem_t        mon_mem;
  logic [9:0]  mon_dq;
  int          total = 0;
  int          bad = 0;
  logic        rd_strobe = 1'b0;
  logic [15:0] mem_model [0:65535];
  logic [47:0] ca;
  logic [15:0] wr_words [4];

  hyperbus_mem_responder #(
    .ADDR_WIDTH (16),
    .WAIT_CYCLES(WAIT_CYCLES),
    .CFG_RESET  (16'h8F1F)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hyper_cs_ni    (hyper_cs_ni),
    .hyper_ck_i     (hyper_ck_i),
    .hyper_dq_i     (hyper_dq_i),
    .hyper_dq_o     (hyper_dq_o),
    .hyper_dq_oe_o  (hyper_dq_oe_o),
    .hyper_rwds_i   (hyper_rwds_i),
    .hyper_rwds_o   (hyper_rwds_o),
    .hyper_rwds_oe_o(hyper_rwds_oe_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_be_o       (mem_be_o),
    .mem_rdata_i    (mem_rdata),
    .cfg_o          (cfg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // SRAM model behind the memory port, preloaded at reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem_model[i] <= 16'h0000;
      mem_model[16'hFFFF] <= 16'hBEEF;
      mem_model[16'h0000] <= 16'h5A5A;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        if (mem_be_o[1]) mem_model[mem_addr_o][15:8] <= mem_wdata_o[15:8];
        if (mem_be_o[0]) mem_model[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
      end else begin
        mem_rdata <= mem_model[mem_addr_o];
      end
    end
  end

  // Memory-port monitor
  always @(negedge clk) begin
    if (!rst && mem_req_o) begin
      if (exp_mem.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_req actual=we%0b@%h data=%h be=%b required=no strobe",
                 mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
      end else begin
        mon_mem = exp_mem.pop_front();
        if (mon_mem.we)
          chk("mem_write", {29'd0, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, {29'd0, mon_mem});
        else
          chk("mem_read", {47'd0, mem_we_o, mem_addr_o}, {47'd0, mon_mem.we, mon_mem.addr});
      end
    end
  end

  // Read-data monitor, sampling each data half just before the next ck edge
  always @(negedge clk) begin
    if (rd_strobe) begin
      if (exp_dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_dq actual=oe%0b rwds%0b dq=%h required=no data",
                 hyper_dq_oe_o, hyper_rwds_o, hyper_dq_o);
      end else begin
        mon_dq = exp_dq.pop_front();
        chk("rd_dq", {54'd0, hyper_dq_oe_o, hyper_rwds_o, hyper_dq_o}, {54'd0, mon_dq});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One ck half-period: data set one clock ahead of the ck toggle
  task automatic half(input logic [7:0] d, input logic r, input logic strobe);
    hyper_dq_i   = d;
    hyper_rwds_i = r;
    tick(1);
    hyper_ck_i = ~hyper_ck_i;
    tick(3);
    rd_strobe = strobe;
    tick(1);
    rd_strobe = 1'b0;
  endtask

  task automatic send_ca(input logic [47:0] c);
    for (int i = 5; i >= 0; i--) half(c[i*8 +: 8], 1'b0, 1'b0);
  endtask

  // Full ck cycles between the CA phase and the first data rising edge
  task automatic lat_fill();
    for (int i = 0; i < 2 * (LAT - 1); i++) half(8'h00, 1'b0, 1'b0);
  endtask

  task automatic begin_txn(input string s);
    $display("txn: %s", s);
    hyper_cs_ni = 1'b0;
    tick(3);
  endtask

  task automatic end_txn();
    tick(3);
    hyper_cs_ni = 1'b1;
    tick(6);
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic [31:0] a);
    mk_ca = {rd, rg, 1'b1, a[31:3], 13'd0, a[2:0]};
  endfunction

  initial begin
    tick(4);
    $display("txn: reset state");
    chk("rst_cfg", cfg_o, 16'h8F1F);
    chk("rst_dq_oe", hyper_dq_oe_o, 1'b0);
    chk("rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_dq", hyper_dq_o, 8'h00);
    rst = 1'b0;
    tick(4);

    // Write burst of 4 words at 0x0010
    wr_words[0] = 16'h1111; wr_words[1] = 16'h2222;
    wr_words[2] = 16'h3333; wr_words[3] = 16'h4444;
    exp_mem.push_back({1'b1, 16'h0010, 16'h1111, 2'b11});
    exp_mem.push_back({1'b1, 16'h0011, 16'h2222, 2'b11});
    exp_mem.push_back({1'b1, 16'h0012, 16'h3333, 2'b11});
    exp_mem.push_back({1'b1, 16'h0013, 16'h4444, 2'b11});
    begin_txn("write burst 4 words @0010");
    ca = mk_ca(1'b0, 1'b0, 32'h10);
    for (int i = 5; i >= 4; i--) half(ca[i*8 +: 8], 1'b0, 1'b0);
    chk("ca_rwds_oe", hyper_rwds_oe_o, 1'b1);
    chk("ca_rwds", hyper_rwds_o, EXP_FLAG);
    for (int i = 3; i >= 0; i--) half(ca[i*8 +: 8], 1'b0, 1'b0);
    lat_fill();
    for (int w = 0; w < 4; w++) begin
      half(wr_words[w][15:8], 1'b0, 1'b0);
      half(wr_words[w][7:0], 1'b0, 1'b0);
    end
    end_txn();

    // Read burst of 3 words at 0x0010 (each rising edge prefetches the next address)
    exp_mem.push_back({1'b0, 16'h0010, 18'd0});
    exp_mem.push_back({1'b0, 16'h0011, 18'd0});
    exp_mem.push_back({1'b0, 16'h0012, 18'd0});
    exp_mem.push_back({1'b0, 16'h0013, 18'd0});
    exp_dq.push_back({2'b11, 8'h11}); exp_dq.push_back({2'b10, 8'h11});
    exp_dq.push_back({2'b11, 8'h22}); exp_dq.push_back({2'b10, 8'h22});
    exp_dq.push_back({2'b11, 8'h33}); exp_dq.push_back({2'b10, 8'h33});
    begin_txn("read burst 3 words @0010");
    send_ca(mk_ca(1'b1, 1'b0, 32'h10));
    lat_fill();
    for (int i = 0; i < 6; i++) half(8'h00, 1'b0, 1'b1);
    end_txn();

    // Masked write: RWDS high on the rising edge masks the first byte
    exp_mem.push_back({1'b1, 16'h0020, 16'hABCD, 2'b01});
    begin_txn("masked write ABCD @0020");
    send_ca(mk_ca(1'b0, 1'b0, 32'h20));
    lat_fill();
    half(8'hAB, 1'b1, 1'b0);
    half(8'hCD, 1'b0, 1'b0);
    end_txn();

    // Register write, no latency and no memory strobe
    begin_txn("register write 8F17");
    send_ca(mk_ca(1'b0, 1'b1, 32'h0));
    half(8'h8F, 1'b0, 1'b0);
    half(8'h17, 1'b0, 1'b0);
    chk("cfg_after_wr", cfg_o, 16'h8F17);
    end_txn();

    // Register read returns the configuration value
    exp_dq.push_back({2'b11, 8'h8F}); exp_dq.push_back({2'b10, 8'h17});
    begin_txn("register read");
    send_ca(mk_ca(1'b1, 1'b1, 32'h0));
    lat_fill();
    half(8'h00, 1'b0, 1'b1);
    half(8'h00, 1'b0, 1'b1);
    end_txn();

    // Read crossing the top of the address space
    exp_mem.push_back({1'b0, 16'hFFFF, 18'd0});
    exp_mem.push_back({1'b0, 16'h0000, 18'd0});
    exp_mem.push_back({1'b0, 16'h0001, 18'd0});
    exp_dq.push_back({2'b11, 8'hBE}); exp_dq.push_back({2'b10, 8'hEF});
    exp_dq.push_back({2'b11, 8'h5A}); exp_dq.push_back({2'b10, 8'h5A});
    begin_txn("read 2 words @FFFF wrap");
    send_ca(mk_ca(1'b1, 1'b0, 32'hFFFF));
    lat_fill();
    for (int i = 0; i < 4; i++) half(8'h00, 1'b0, 1'b1);
    end_txn();

    // CS released after 3 CA bytes
    begin_txn("abort after 3 CA bytes");
    ca = mk_ca(1'b1, 1'b0, 32'h40);
    for (int i = 5; i >= 3; i--) half(ca[i*8 +: 8], 1'b0, 1'b0);
    hyper_cs_ni = 1'b1;
    tick(4);
    chk("abort_rwds_oe", hyper_rwds_oe_o, 1'b0);
    chk("abort_dq_oe", hyper_dq_oe_o, 1'b0);
    hyper_ck_i = 1'b0;
    tick(6);

    // Following transaction decodes normally
    exp_mem.push_back({1'b0, 16'h0012, 18'd0});
    exp_mem.push_back({1'b0, 16'h0013, 18'd0});
    exp_dq.push_back({2'b11, 8'h33}); exp_dq.push_back({2'b10, 8'h33});
    begin_txn("read 1 word @0012 after abort");
    send_ca(mk_ca(1'b1, 1'b0, 32'h12));
    lat_fill();
    half(8'h00, 1'b0, 1'b1);
    half(8'h00, 1'b0, 1'b1);
    end_txn();

    // Half a write word before CS rises must not reach memory
    exp_mem.push_back({1'b1, 16'h0030, 16'h5555, 2'b11});
    begin_txn("write 1 word + partial @0030");
    send_ca(mk_ca(1'b0, 1'b0, 32'h30));
    lat_fill();
    half(8'h55, 1'b0, 1'b0);
    half(8'h55, 1'b0, 1'b0);
    half(8'h66, 1'b0, 1'b0);
    hyper_cs_ni = 1'b1;
    tick(4);
    hyper_ck_i = 1'b0;
    tick(8);

    // Asynchronous reset in the middle of the CA phase
    begin_txn("reset during CA");
    ca = mk_ca(1'b0, 1'b0, 32'h0);
    for (int i = 5; i >= 2; i--) half(ca[i*8 +: 8], 1'b0, 1'b0);
    chk("pre_rst_rwds_oe", hyper_rwds_oe_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
    chk("mid_rst_cfg", cfg_o, 16'h8F1F);
    hyper_cs_ni = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(6);

    chk("exp_mem_left", exp_mem.size(), 0);
    chk("exp_dq_left", exp_dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
